// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: stabilisation wait, precharge-all,
// NUM_REF auto-refreshes and mode-register load, then hands the bus over via o_init_done.
module sdram_init_seq #(
   parameter int unsigned       T_WAIT   = 10000,
   parameter int unsigned       T_RP     = 3,
   parameter int unsigned       T_RFC    = 7,
   parameter int unsigned       T_MRD    = 2,
   parameter int unsigned       NUM_REF  = 8,
   parameter int unsigned       ADDR_W   = 13,
   parameter int unsigned       BA_W     = 2,
   parameter logic [ADDR_W-1:0] MODE_REG = ADDR_W'(13'h0032)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_init_req,
   output logic              o_cke,
   output logic [3:0]        o_cmd,
   output logic [ADDR_W-1:0] o_addr,
   output logic [BA_W-1:0]   o_ba,
   output logic              o_init_done
);

   localparam int unsigned MaxT0 = (T_WAIT > T_RP) ? T_WAIT : T_RP;
   localparam int unsigned MaxT1 = (T_RFC > T_MRD) ? T_RFC : T_MRD;
   localparam int unsigned MaxT  = (MaxT0 > MaxT1) ? MaxT0 : MaxT1;
   localparam int unsigned CntW  = $clog2(MaxT + 1);
   localparam int unsigned RefW  = $clog2(NUM_REF + 1);

   localparam logic [3:0] CmdInhibit = 4'b1111;
   localparam logic [3:0] CmdNop     = 4'b0111;
   localparam logic [3:0] CmdPre     = 4'b0010;
   localparam logic [3:0] CmdRef     = 4'b0001;
   localparam logic [3:0] CmdMrs     = 4'b0000;

   // A10 high selects all banks for PRECHARGE
   localparam logic [ADDR_W-1:0] AddrPreAll = ADDR_W'(11'h400);

   typedef enum logic [2:0] {
      StReset,
      StWait,
      StPre,
      StRef,
      StMrs,
      StDone
   } state_e;

   state_e state_q, state_d;

   // cnt_q holds the number of NOP cycles still owed in the current state
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [RefW-1:0]   ref_q, ref_d;
   logic              cke_q, cke_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BA_W-1:0]   ba_q, ba_d;
   logic              done_q, done_d;

   assign o_cke       = cke_q;
   assign o_cmd       = cmd_q;
   assign o_addr      = addr_q;
   assign o_ba        = ba_q;
   assign o_init_done = done_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ref_d   = ref_q;
      cke_d   = 1'b1;
      cmd_d   = CmdNop;
      addr_d  = '0;
      ba_d    = '0;
      done_d  = 1'b0;

      unique case (state_q)
         StReset: begin
            state_d = StWait;
            cnt_d   = CntW'(T_WAIT - 1);
            ref_d   = '0;
         end

         StWait: begin
            if (cnt_q == '0) begin
               state_d = StPre;
               cmd_d   = CmdPre;
               addr_d  = AddrPreAll;
               cnt_d   = CntW'(T_RP - 1);
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end

         StPre: begin
            if (cnt_q == '0) begin
               state_d = StRef;
               cmd_d   = CmdRef;
               cnt_d   = CntW'(T_RFC - 1);
               ref_d   = RefW'(1);
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end

         StRef: begin
            // ref_q counts refreshes already issued; the last one keeps its full gap
            if (cnt_q == '0) begin
               if (ref_q == RefW'(NUM_REF)) begin
                  state_d = StMrs;
                  cmd_d   = CmdMrs;
                  addr_d  = MODE_REG;
                  cnt_d   = CntW'(T_MRD - 1);
                  ref_d   = '0;
               end else begin
                  cmd_d = CmdRef;
                  cnt_d = CntW'(T_RFC - 1);
                  ref_d = ref_q + RefW'(1);
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end

         StMrs: begin
            if (cnt_q == '0) begin
               state_d = StDone;
               done_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end

         StDone: begin
            // Re-init skips the stabilisation wait; CKE is never dropped
            if (i_init_req) begin
               state_d = StPre;
               cmd_d   = CmdPre;
               addr_d  = AddrPreAll;
               cnt_d   = CntW'(T_RP - 1);
               ref_d   = '0;
            end else begin
               done_d = 1'b1;
            end
         end

         default: begin
            state_d = StReset;
            cnt_d   = '0;
            ref_d   = '0;
            cke_d   = 1'b0;
            cmd_d   = CmdInhibit;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StReset;
         cnt_q   <= '0;
         ref_q   <= '0;
         cke_q   <= 1'b0;
         cmd_q   <= CmdInhibit;
         addr_q  <= '0;
         ba_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ref_q   <= ref_d;
         cke_q   <= cke_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         ba_q    <= ba_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Self-checking bench for sdram_init_seq: directed scenarios plus randomized re-init
// requests and resets, checked against a timeline model of the init sequence.
module tb_sdram_init_seq;

   localparam int TW   = 5;
   localparam int TRP  = 2;
   localparam int TRFC = 3;
   localparam int TMRD = 2;
   localparam int NREF = 2;

   localparam logic [3:0]  C_INH   = 4'b1111;
   localparam logic [3:0]  C_NOP   = 4'b0111;
   localparam logic [3:0]  C_PRE   = 4'b0010;
   localparam logic [3:0]  C_REF   = 4'b0001;
   localparam logic [3:0]  C_MRS   = 4'b0000;
   localparam logic [20:0] RST_VEC = {1'b0, 4'b1111, 13'h0, 2'b00, 1'b0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, req_a, cke_a, done_a;
   logic [3:0]  cmd_a;
   logic [12:0] addr_a;
   logic [1:0]  ba_a;
   logic        rst_b, req_b, cke_b, done_b;
   logic [3:0]  cmd_b;
   logic [12:0] addr_b;
   logic [1:0]  ba_b;
   logic [20:0] obs_a, obs_b;

   assign obs_a = {cke_a, cmd_a, addr_a, ba_a, done_a};
   assign obs_b = {cke_b, cmd_b, addr_b, ba_b, done_b};

   sdram_init_seq #(
      .T_WAIT (TW),
      .T_RP   (TRP),
      .T_RFC  (TRFC),
      .T_MRD  (TMRD),
      .NUM_REF(NREF)
   ) u_dut_a (
      .i_clk      (clk),
      .i_rst      (rst_a),
      .i_init_req (req_a),
      .o_cke      (cke_a),
      .o_cmd      (cmd_a),
      .o_addr     (addr_a),
      .o_ba       (ba_a),
      .o_init_done(done_a)
   );

   sdram_init_seq #(
      .T_WAIT (1),
      .T_RP   (1),
      .T_RFC  (1),
      .T_MRD  (1),
      .NUM_REF(1)
   ) u_dut_b (
      .i_clk      (clk),
      .i_rst      (rst_b),
      .i_init_req (req_b),
      .o_cke      (cke_b),
      .o_cmd      (cmd_b),
      .o_addr     (addr_b),
      .o_ba       (ba_b),
      .o_init_done(done_b)
   );

   int total = 0;
   int bad   = 0;
   int pos;   // cycles since the current sequence started
   int cyc;   // cycles since the last reset release
   bit full;  // current sequence includes the stabilisation wait

   // Expected {cke, cmd, addr, ba, done} at offset p of a sequence, laid out as
   // consecutive phases: wait, precharge, refreshes, mode load, then done.
   function automatic logic [20:0] model_out(int p, bit f, int tw, int trp, int trfc,
                                             int tmrd, int nref);
      int          k;
      logic [3:0]  c;
      logic [12:0] ad;
      logic        dn;
      if (p < 0) return RST_VEC;
      k  = f ? p - tw : p;
      c  = C_NOP;
      ad = 13'h0;
      dn = 1'b0;
      if (k >= 0) begin
         if (k < trp) begin
            if (k == 0) begin
               c  = C_PRE;
               ad = 13'h0400;
            end
         end else begin
            k = k - trp;
            if (k < nref * trfc) begin
               if (k % trfc == 0) c = C_REF;
            end else begin
               k = k - nref * trfc;
               if (k < tmrd) begin
                  if (k == 0) begin
                     c  = C_MRS;
                     ad = 13'h0032;
                  end
               end else begin
                  dn = 1'b1;
               end
            end
         end
      end
      return {1'b1, c, ad, 2'b00, dn};
   endfunction

   task automatic model_step(input logic [20:0] e, input logic r);
      if (e[0] && r) begin
         pos  = 0;
         full = 1'b0;
      end else begin
         pos++;
      end
      cyc++;
   endtask

   // Leaves the bench at the negedge where reset is released
   task automatic reset_a();
      @(negedge clk);
      req_a = 1'b0;
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      pos   = 0;
      full  = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_a = 1'b1;
      req_a = 1'b1;
      #1;
      total++;
      if (cke_a !== 1'b0) begin
         bad++; $display("FAIL reset_cke got=%b want=0", cke_a);
      end
      total++;
      if (cmd_a !== C_INH) begin
         bad++; $display("FAIL reset_cmd got=%b want=%b", cmd_a, C_INH);
      end
      total++;
      if (addr_a !== 13'h0) begin
         bad++; $display("FAIL reset_addr got=%h want=0", addr_a);
      end
      total++;
      if (ba_a !== 2'b00) begin
         bad++; $display("FAIL reset_ba got=%b want=0", ba_a);
      end
      total++;
      if (done_a !== 1'b0) begin
         bad++; $display("FAIL reset_done got=%b want=0", done_a);
      end
      @(negedge clk);
      rst_a = 1'b0;
      req_a = 1'b0;
      pos   = 0;
      full  = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_nominal();
      logic [20:0] e;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         e = model_out(pos, full, TW, TRP, TRFC, TMRD, NREF);
         total++;
         if (obs_a !== e) begin
            bad++; $display("FAIL nominal cyc=%0d got=%h want=%h", cyc, obs_a, e);
         end
         if (cyc == 5) begin
            total++;
            if (cmd_a !== C_PRE || addr_a !== 13'h0400) begin
               bad++; $display("FAIL nominal_pre cmd=%b addr=%h want=%b/0400", cmd_a, addr_a, C_PRE);
            end
         end
         if (cyc == 15) begin
            total++;
            if (done_a !== 1'b1) begin
               bad++; $display("FAIL nominal_done got=%b want=1", done_a);
            end
         end
         req_a = 1'b0;
         model_step(e, req_a);
      end
   endtask

   task automatic test_reinit();
      logic [20:0] e;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         e = model_out(pos, full, TW, TRP, TRFC, TMRD, NREF);
         total++;
         if (obs_a !== e) begin
            bad++; $display("FAIL reinit cyc=%0d got=%h want=%h", cyc, obs_a, e);
         end
         if (cyc == 21) begin
            total++;
            if (cmd_a !== C_PRE || done_a !== 1'b0 || cke_a !== 1'b1) begin
               bad++; $display("FAIL reinit_pre cmd=%b done=%b cke=%b want=%b/0/1", cmd_a, done_a, cke_a, C_PRE);
            end
         end
         if (cyc == 31) begin
            total++;
            if (done_a !== 1'b1) begin
               bad++; $display("FAIL reinit_done got=%b want=1", done_a);
            end
         end
         req_a = (cyc == 20);
         model_step(e, req_a);
      end
      req_a = 1'b0;
   endtask

   task automatic test_ignored_req();
      logic [20:0] e;
      reset_a();
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         e = model_out(pos, full, TW, TRP, TRFC, TMRD, NREF);
         total++;
         if (obs_a !== e) begin
            bad++; $display("FAIL ignored_req cyc=%0d got=%h want=%h", cyc, obs_a, e);
         end
         if (cyc == 16) begin
            total++;
            if (cmd_a !== C_PRE || done_a !== 1'b0) begin
               bad++; $display("FAIL ignored_req_pre cmd=%b done=%b want=%b/0", cmd_a, done_a, C_PRE);
            end
         end
         req_a = (cyc <= 15);
         model_step(e, req_a);
      end
      req_a = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [20:0] e;
      reset_a();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         e = model_out(pos, full, TW, TRP, TRFC, TMRD, NREF);
         total++;
         if (obs_a !== e) begin
            bad++; $display("FAIL reset_mid_pre cyc=%0d got=%h want=%h", cyc, obs_a, e);
         end
         model_step(e, req_a);
      end
      #2 rst_a = 1'b1;
      #1;
      total++;
      if (obs_a !== RST_VEC) begin
         bad++; $display("FAIL reset_mid_async got=%h want=%h", obs_a, RST_VEC);
      end
      @(negedge clk);
      rst_a = 1'b0;
      pos   = 0;
      full  = 1'b1;
      cyc   = 0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         e = model_out(pos, full, TW, TRP, TRFC, TMRD, NREF);
         total++;
         if (obs_a !== e) begin
            bad++; $display("FAIL reset_mid_post cyc=%0d got=%h want=%h", cyc, obs_a, e);
         end
         if (cyc == 15) begin
            total++;
            if (done_a !== 1'b1) begin
               bad++; $display("FAIL reset_mid_done got=%b want=1", done_a);
            end
         end
         model_step(e, req_a);
      end
   endtask

   task automatic test_random();
      logic [20:0] e;
      for (int r = 0; r < 5; r++) begin
         int rst_at;
         bit rst_used;
         reset_a();
         rst_at   = $urandom_range(2, 40);
         rst_used = 1'b0;
         for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            e = model_out(pos, full, TW, TRP, TRFC, TMRD, NREF);
            total++;
            if (obs_a !== e) begin
               bad++; $display("FAIL random r=%0d cyc=%0d got=%h want=%h", r, cyc, obs_a, e);
            end
            req_a = ($urandom_range(0, 2) == 0);
            if (!rst_used && cyc == rst_at) begin
               rst_used = 1'b1;
               #2 rst_a = 1'b1;
               #1;
               total++;
               if (obs_a !== RST_VEC) begin
                  bad++; $display("FAIL random_async_rst r=%0d got=%h want=%h", r, obs_a, RST_VEC);
               end
               @(negedge clk);
               rst_a = 1'b0;
               pos   = 0;
               full  = 1'b1;
               cyc   = 0;
            end else begin
               model_step(e, req_a);
            end
         end
      end
      req_a = 1'b0;
   endtask

   task automatic test_min_spacing();
      logic [20:0] e;
      int          p;
      @(negedge clk);
      rst_b = 1'b0;
      p     = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         e = model_out(p, 1'b1, 1, 1, 1, 1, 1);
         total++;
         if (obs_b !== e) begin
            bad++; $display("FAIL min_spacing cyc=%0d got=%h want=%h", p, obs_b, e);
         end
         if (p >= 1 && p <= 3) begin
            total++;
            if (cmd_b === C_NOP) begin
               bad++; $display("FAIL min_spacing_no_nop cyc=%0d got=%b", p, cmd_b);
            end
         end
         if (p == 4) begin
            total++;
            if (done_b !== 1'b1) begin
               bad++; $display("FAIL min_spacing_done got=%b want=1", done_b);
            end
         end
         p++;
      end
   endtask

   initial begin
      rst_a = 1'b1;
      req_a = 1'b0;
      rst_b = 1'b1;
      req_b = 1'b0;
      pos   = 0;
      cyc   = 0;
      full  = 1'b1;
      test_reset();
      test_nominal();
      test_reinit();
      test_ignored_req();
      test_reset_mid();
      test_random();
      test_min_spacing();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
